clk_div_multi: RTL and testbench

Multi-channel programmable clock divider generating NUM_CH independent divided clocks from one reference clock. Supports both even and odd integer ratios, and applies ratio changes only at divided-clock period boundaries so no runt pulses appear. Each channel has an optional period-start tick. The block sits in the clocking subsystem and feeds per-domain clocks, for example UART TX/RX and peripheral clocks, from the shared reference.

---
 rtl/clk_div_multi.sv | 81 ++++++++
 tb/tb_clk_div_multi.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel even/odd integer clock divider with glitch-free ratio changes
// Optional period-start tick outputs are built when CLK_DIV_MULTI_TICK_EN is defined.
module clk_div_multi #(
    parameter int RATIO_WIDTH = 8,
    parameter int NUM_CH      = 4
) (
    input  logic                          I_ref_clk,
    input  logic                          I_rst,
    input  logic [NUM_CH-1:0]             I_clk_en,
    input  logic [NUM_CH*RATIO_WIDTH-1:0] I_div_ratio,
    output logic [NUM_CH-1:0]             O_div_clk,
    output logic [NUM_CH-1:0]             O_tick,
    output logic [NUM_CH*RATIO_WIDTH-1:0] O_active_ratio
);

    localparam logic [RATIO_WIDTH-1:0] ONE = RATIO_WIDTH'(1);
    localparam logic [RATIO_WIDTH-1:0] TWO = RATIO_WIDTH'(2);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [RATIO_WIDTH-1:0] req;
        logic [RATIO_WIDTH-1:0] cnt;
        logic [RATIO_WIDTH-1:0] act_ratio;
        logic [RATIO_WIDTH-1:0] cnt_nxt;
        logic [RATIO_WIDTH-1:0] nxt_ratio;
        logic [RATIO_WIDTH-1:0] half;
        logic                   div_q;
        logic                   idle;
        logic                   wrap;

        assign req  = I_div_ratio[c*RATIO_WIDTH +: RATIO_WIDTH];
        assign idle = !I_clk_en[c] || (act_ratio < TWO);

        // The requested ratio is only sampled at a wrap, so H always matches the period it shapes.
        always_comb begin
            cnt_nxt   = (cnt == act_ratio - ONE) ? '0 : cnt + ONE;
            wrap      = (cnt_nxt == '0);
            nxt_ratio = wrap ? req : act_ratio;
            half      = (nxt_ratio >> 1) + {{(RATIO_WIDTH-1){1'b0}}, nxt_ratio[0]};
        end

        always_ff @(posedge I_ref_clk or posedge I_rst) begin
            if (I_rst) begin
                cnt       <= '0;
                act_ratio <= '0;
                div_q     <= 1'b0;
            end else if (idle) begin
                act_ratio <= I_clk_en[c] ? req : '0;
                cnt       <= (req >= TWO) ? req - ONE : '0;
                div_q     <= 1'b0;
            end else if (wrap && (req < TWO)) begin
                act_ratio <= req;
                cnt       <= '0;
                div_q     <= 1'b0;
            end else begin
                act_ratio <= nxt_ratio;
                cnt       <= cnt_nxt;
                div_q     <= (cnt_nxt < half);
            end
        end

`ifdef CLK_DIV_MULTI_TICK_EN
        logic tick_q;

        always_ff @(posedge I_ref_clk or posedge I_rst) begin
            if (I_rst) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= !idle && wrap && (req >= TWO);
            end
        end

        assign O_tick[c] = tick_q;
`else
        assign O_tick[c] = 1'b0;
`endif

        assign O_div_clk[c] = idle ? I_ref_clk : div_q;
        assign O_active_ratio[c*RATIO_WIDTH +: RATIO_WIDTH] = act_ratio;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
module tb_clk_div_multi;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   en;
    logic [N*W-1:0] ratio;
    logic [N-1:0]   div;
    logic [N-1:0]   tick;
    logic [N*W-1:0] act;

    int checks   = 0;
    int failures = 0;
    int rs[4] = '{2, 3, 7, 255};

    always #5 clk = ~clk;

    clk_div_multi #(.RATIO_WIDTH(W), .NUM_CH(N)) dut (
        .I_ref_clk      (clk),
        .I_rst          (rst),
        .I_clk_en       (en),
        .I_div_ratio    (ratio),
        .O_div_clk      (div),
        .O_tick         (tick),
        .O_active_ratio (act)
    );

    function automatic logic t_exp(input logic b);
`ifdef CLK_DIV_MULTI_TICK_EN
        return b;
`else
        return 1'b0 & b;
`endif
    endfunction

    function automatic logic exp_div(input int k, input int r);
        return (k % r) < (r / 2 + r % 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ch(input string tag, input int c, input logic d, input logic t);
        chk({tag, "_div"}, 32'(div[c]), 32'(d));
        chk({tag, "_tick"}, 32'(tick[c]), 32'(t_exp(t)));
    endtask

    task automatic chk_act(input string tag, input int c, input int r);
        logic [W-1:0] a;
        a = act[c*W +: W];
        chk(tag, 32'(a), 32'(r));
    endtask

    task automatic set_ratio(input int c, input int r);
        ratio[c*W +: W] = r[W-1:0];
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic low_phase;
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst   = 1'b1;
        en    = '0;
        ratio = '0;
        #7;
        chk("rst_tick", 32'(tick), 32'(0));
        chk("rst_act", act, 32'(0));
        chk("rst_div_hi", 32'(div), 32'(4'b1111));
        low_phase;
        chk("rst_div_lo", 32'(div), 32'(4'b0000));
        rst = 1'b0;

        // ch0 at ratio 4, then switch to 6 while cnt=1
        en = 4'b0001;
        set_ratio(0, 4);
        step;
        chk_ch("r4_e1", 0, 1'b0, 1'b0);
        chk_act("r4_act", 0, 4);
        chk("r4_byp_hi", 32'(div[3:1]), 32'(3'b111));
        step;
        chk_ch("r4_e2", 0, 1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step;
            chk_ch("r4_run", 0, exp_div(k, 4), (k % 4) == 0);
            chk("r4_byp", 32'(div[3:1]), 32'(3'b111));
        end
        set_ratio(0, 6);
        for (int k = 6; k <= 7; k++) begin
            step;
            chk_ch("r4_tail", 0, 1'b0, 1'b0);
            chk_act("r4_tail_act", 0, 4);
        end
        for (int j = 0; j < 12; j++) begin
            step;
            chk_ch("r6_run", 0, exp_div(j, 6), (j % 6) == 0);
            chk_act("r6_act", 0, 6);
        end
        low_phase;
        chk("r6_byp_lo", 32'(div[3:1]), 32'(3'b000));

        // ch1 ratio 5, then ratio 2
        en = 4'b0011;
        set_ratio(1, 5);
        step;
        chk_ch("r5_e1", 1, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            step;
            chk_ch("r5_run", 1, exp_div(j, 5), (j % 5) == 0);
            chk_act("r5_act", 1, 5);
        end
        set_ratio(1, 2);
        for (int j = 0; j < 6; j++) begin
            step;
            chk_ch("r2_run", 1, exp_div(j, 2), (j % 2) == 0);
            chk_act("r2_act", 1, 2);
        end

        // ch2 ratios 0 and 1 bypass, then 8 -> 1 at the wrap
        en = 4'b0111;
        set_ratio(2, 0);
        step;
        chk_act("r0_act", 2, 0);
        chk("r0_hi", 32'(div[2]), 32'(1));
        low_phase;
        chk("r0_lo", 32'(div[2]), 32'(0));
        set_ratio(2, 1);
        step;
        chk_act("r1_act", 2, 1);
        chk("r1_hi", 32'(div[2]), 32'(1));
        low_phase;
        chk("r1_lo", 32'(div[2]), 32'(0));
        set_ratio(2, 8);
        step;
        chk_ch("r8_e1", 2, 1'b0, 1'b0);
        chk_act("r8_act", 2, 8);
        for (int j = 0; j < 8; j++) begin
            step;
            chk_ch("r8_run", 2, exp_div(j, 8), j == 0);
            if (j == 3) set_ratio(2, 1);
        end
        step;
        chk_act("r8to1_act", 2, 1);
        chk("r8to1_tick", 32'(tick[2]), 32'(0));
        chk("r8to1_hi", 32'(div[2]), 32'(1));
        low_phase;
        chk("r8to1_lo", 32'(div[2]), 32'(0));

        // four channels 2,3,7,255 from a clean reset
        rst = 1'b1;
        #1;
        chk("rst2_act", act, 32'(0));
        low_phase;
        rst = 1'b0;
        en  = 4'b1111;
        for (int c = 0; c < N; c++) set_ratio(c, rs[c]);
        step;
        chk("all_e1", 32'(div), 32'(4'b0000));
        for (int k = 0; k <= 258; k++) begin
            step;
            for (int c = 0; c < N; c++) begin
                if (c == 2 && k > 12) begin
                    chk("dis_byp", 32'(div[2]), 32'(clk));
                    chk_act("dis_act", 2, 0);
                end else begin
                    chk_ch("multi", c, exp_div(k, rs[c]), (k % rs[c]) == 0);
                end
            end
            if (k == 12) begin
                en[2] = 1'b0;
                #1;
                chk("dis_immediate", 32'(div[2]), 32'(clk));
            end
        end
        rst = 1'b1;
        #1;
        chk("async_rst_tick", 32'(tick), 32'(0));
        chk("async_rst_act", act, 32'(0));
        chk("async_rst_div", 32'(div), 32'(4'b1111));
        low_phase;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
